muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M integer multiply/divide functional unit sitting directly downstream of the integer-M reservation station. Accepts one issued instruction per `fu_start` pulse, computes the result (multiply in 2 cycles, divide in 33 cycles), and holds it on a request/grant port to the CDB arbiter until granted. Signals availability back to the reservation station through `fu_ready`.

## Interface
- `DATA_WIDTH`, 32: operand/result width. Only 32 is supported.
- `TAG_WIDTH`, 3: ROB tag width; must match the reservation station.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fu_start` in 1: one-cycle issue pulse from the reservation station.
- `fu_op1`, `fu_op2` in DATA_WIDTH: rs1 and rs2 values.
- `fu_op3` in DATA_WIDTH: ignored by this unit.
- `fu_opcode` in 5: M-extension operation code.
- `fu_dest_tag` in TAG_WIDTH: ROB tag of the instruction.
- `fu_dest_reg` in 5: architectural destination register.
- `fu_ready` out 1: unit can accept `fu_start` this cycle.
- `flush` in 1: mispredict squash; abandons any in-flight operation.
- `cdb_req` out 1: result valid, requesting the CDB.
- `cdb_grant` in 1: arbiter accepts the result this cycle.
- `cdb_tag` out TAG_WIDTH: result ROB tag.
- `cdb_value` out DATA_WIDTH: result value.
- `cdb_dest_reg` out 5: result destination register.

## Operation
- Opcodes:
  - MUL=0: low 32 bits of the product.
  - MULH=1, MULHSU=2, MULHU=3: high 32 bits of the product.
    - MULH treats both operands as signed.
    - MULHSU treats op1 as signed and op2 as unsigned.
    - MULHU treats both operands as unsigned.
  - DIV=4, DIVU=5, REM=6, REMU=7.
  - Opcodes 8–31 produce result 0 via the MUL path.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - On `fu_start`, latch operands, opcode, tag and destination register.
  - Multiply or illegal opcode: go to MUL.
  - Divide with divisor 0: go directly to DONE.
    - Quotient = 0xFFFFFFFF.
    - Remainder = dividend.
  - Signed divide of 0x80000000 by 0xFFFFFFFF: go directly to DONE.
    - Quotient = 0x80000000.
    - Remainder = 0.
  - Any other divide: go to DIV.
- MUL:
  - Form the 65-bit signed product of sign- or zero-extended operands.
  - Register the selected half into the result; go to DONE.
- DIV:
  - Radix-2 restoring division on operand magnitudes; 32 iteration cycles, then DONE.
  - Quotient sign = XOR of the operand signs (signed ops only).
  - Remainder sign follows the dividend.
  - Sign fix-up is applied when entering DONE.
- DONE:
  - `cdb_req`=1; outputs are stable.
  - When `cdb_grant`=1, go to IDLE next cycle.
- `fu_ready` = (state==IDLE) && !`fu_start`. This is combinational and blocks a back-to-back issue by the reservation station, which registers `fu_start` one cycle after sampling `fu_ready`.
- `flush`:
  - Highest priority; next state is IDLE.
  - `cdb_req` goes to 0 next cycle.
  - A `fu_start` arriving in the same cycle is dropped.
  - `cdb_grant` in the same cycle is treated as not granted.

## Timing
- Reset: state=IDLE; `cdb_req`=0; `cdb_tag`, `cdb_value`, `cdb_dest_reg` = 0; `fu_ready`=1.
- Reset asserted mid-operation aborts the operation immediately.
- Take `fu_start` high in cycle c. Then `cdb_req` first goes high:
  - Multiply: cycle c+2.
  - Divide special case: cycle c+1.
  - Normal divide: cycle c+33.
- Granted in cycle g: `cdb_req`=0 and `fu_ready`=1 in cycle g+1; the next `fu_start` is accepted no earlier than g+1.
- No grant: hold in DONE indefinitely with outputs unchanged.
- `cdb_*` outputs change only on entry to DONE.
- Throughput: one operation in flight.

## Structure
- Shared package `rv_m_pkg`:
  - Opcode localparams MUL through REMU.
  - FSM state encoding.
  - DIV iteration count 32.
- Sub-module `div_iter`:
  - Restoring divider core with start/done interface.
  - Unsigned magnitudes in, quotient and remainder out.
  - Synchronous clear, driven by `flush`.
- Top level holds the FSM, multiplier, sign handling and CDB holding registers.

## Test plan
- MUL 7×(−3), tag 5, rd 10:
  - `cdb_req` at c+2 with value 0xFFFFFFEB, tag 5, rd 10.
  - `fu_ready` low in cycles c to c+2.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH 0x80000000×0x80000000 → 0x40000000.
- MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −20/3 → −6 (0xFFFFFFFA) at c+33; REM −20/3 → −2; REMU 20/3 → 2.
- Special cases, each with `cdb_req` at c+1:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000; REM of the same → 0.
- Grant withheld 10 cycles after a MUL:
  - `cdb_req` and value stable throughout.
  - Grant in cycle g → `fu_ready`=1 at g+1.
  - Second `fu_start` accepted at g+1.
- `flush` at c+10 of a DIV: no `cdb_req` ever for that op; IDLE at c+11; a new MUL issued at c+11 completes normally at c+13.
- Reset asserted at c+5 of a DIV: all outputs at reset values immediately; `fu_ready`=1.

Source files
------------

// File: rtl/rv_m_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: opcodes, FSM encoding
// and the divider iteration count.
package rv_m_pkg;

   localparam logic [4:0] OP_MUL    = 5'd0;
   localparam logic [4:0] OP_MULH   = 5'd1;
   localparam logic [4:0] OP_MULHSU = 5'd2;
   localparam logic [4:0] OP_MULHU  = 5'd3;
   localparam logic [4:0] OP_DIV    = 5'd4;
   localparam logic [4:0] OP_DIVU   = 5'd5;
   localparam logic [4:0] OP_REM    = 5'd6;
   localparam logic [4:0] OP_REMU   = 5'd7;

   localparam int DIV_ITERS = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic is_div_op(input logic [4:0] op);
      return op[4:2] == 3'b001;
   endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes. The first iteration is
// folded into the start cycle so done rises DIV_ITERS cycles after start.
module div_iter
   import rv_m_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);

   localparam int CW = $clog2(DIV_ITERS) + 1;
   localparam logic [CW-1:0] LAST = CW'(DIV_ITERS);

   logic          busy;
   logic [CW-1:0] cnt;
   logic [W-1:0]  quo, rem, dsr;
   logic [W-1:0]  src_q, src_r, src_d, nxt_q, nxt_r;
   logic [W:0]    shifted;

   always_comb begin
      src_q   = start ? dividend : quo;
      src_r   = start ? '0 : rem;
      src_d   = start ? divisor : dsr;
      shifted = {src_r, src_q[W-1]};
      if (shifted >= {1'b0, src_d}) begin
         // True difference is below the divisor, so the low W bits are exact.
         nxt_r = shifted[W-1:0] - src_d;
         nxt_q = {src_q[W-2:0], 1'b1};
      end else begin
         nxt_r = shifted[W-1:0];
         nxt_q = {src_q[W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         cnt  <= '0;
         quo  <= '0;
         rem  <= '0;
         dsr  <= '0;
      end else if (clr) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= CW'(1);
         quo  <= nxt_q;
         rem  <= nxt_r;
         dsr  <= divisor;
      end else if (busy && cnt != LAST) begin
         cnt  <= cnt + CW'(1);
         quo  <= nxt_q;
         rem  <= nxt_r;
      end else if (busy) begin
         busy <= 1'b0;
      end
   end

   assign done      = busy && (cnt == LAST);
   assign quotient  = quo;
   assign remainder = rem;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide functional unit: one operation in flight, result held
// on a request/grant port to the CDB arbiter until accepted.
module muldiv_unit
   import rv_m_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fu_start,
   input  logic [DATA_WIDTH-1:0] fu_op1,
   input  logic [DATA_WIDTH-1:0] fu_op2,
   input  logic [DATA_WIDTH-1:0] fu_op3,
   input  logic [4:0]            fu_opcode,
   input  logic [TAG_WIDTH-1:0]  fu_dest_tag,
   input  logic [4:0]            fu_dest_reg,
   output logic                  fu_ready,
   input  logic                  flush,
   output logic                  cdb_req,
   input  logic                  cdb_grant,
   output logic [TAG_WIDTH-1:0]  cdb_tag,
   output logic [DATA_WIDTH-1:0] cdb_value,
   output logic [4:0]            cdb_dest_reg
);

   localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   state_t                state;
   logic [DATA_WIDTH-1:0] op_a, op_b;
   logic [4:0]            opc;
   logic [TAG_WIDTH-1:0]  tag_q;
   logic [4:0]            rd_q;

   logic                    signed_in, rem_in, div_zero, div_ovf, div_start;
   logic [DATA_WIDTH-1:0]   special_val, mag_a, mag_b;
   logic                    sa, sb, signed_q, q_neg, r_neg;
   logic [2*DATA_WIDTH-1:0] a_ext, b_ext, prod;
   logic [DATA_WIDTH-1:0]   mul_val, div_val, qm, rm;
   logic                    div_done;
   logic                    unused_op3;

   assign unused_op3 = ^fu_op3;
   assign fu_ready   = (state == S_IDLE) && !fu_start;

   // Issue-side decode works on the live operands so special divides can
   // complete the cycle after issue.
   always_comb begin
      signed_in   = (fu_opcode == OP_DIV) || (fu_opcode == OP_REM);
      rem_in      = (fu_opcode == OP_REM) || (fu_opcode == OP_REMU);
      div_zero    = (fu_op2 == '0);
      div_ovf     = signed_in && (fu_op1 == INT_MIN) && (fu_op2 == '1);
      special_val = div_zero ? (rem_in ? fu_op1 : '1) : (rem_in ? '0 : fu_op1);
      mag_a       = (signed_in && fu_op1[DATA_WIDTH-1]) ? -fu_op1 : fu_op1;
      mag_b       = (signed_in && fu_op2[DATA_WIDTH-1]) ? -fu_op2 : fu_op2;
      div_start   = (state == S_IDLE) && fu_start && !flush && is_div_op(fu_opcode)
                    && !div_zero && !div_ovf;
   end

   // The low 64 bits of the sign/zero-extended product carry both halves.
   always_comb begin
      sa      = (opc == OP_MULH) || (opc == OP_MULHSU);
      sb      = (opc == OP_MULH);
      a_ext   = {{DATA_WIDTH{sa & op_a[DATA_WIDTH-1]}}, op_a};
      b_ext   = {{DATA_WIDTH{sb & op_b[DATA_WIDTH-1]}}, op_b};
      prod    = a_ext * b_ext;
      mul_val = '0;
      case (opc)
         OP_MUL:                       mul_val = prod[DATA_WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: mul_val = prod[2*DATA_WIDTH-1:DATA_WIDTH];
         default:                      mul_val = '0;
      endcase
   end

   always_comb begin
      signed_q = (opc == OP_DIV) || (opc == OP_REM);
      q_neg    = signed_q && (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
      r_neg    = signed_q && op_a[DATA_WIDTH-1];
      if ((opc == OP_REM) || (opc == OP_REMU)) div_val = r_neg ? -rm : rm;
      else                                     div_val = q_neg ? -qm : qm;
   end

   div_iter #(.W(DATA_WIDTH)) u_div (
      .clk       (clk),
      .rst       (rst),
      .clr       (flush),
      .start     (div_start),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .done      (div_done),
      .quotient  (qm),
      .remainder (rm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         op_a         <= '0;
         op_b         <= '0;
         opc          <= '0;
         tag_q        <= '0;
         rd_q         <= '0;
         cdb_req      <= 1'b0;
         cdb_tag      <= '0;
         cdb_value    <= '0;
         cdb_dest_reg <= '0;
      end else if (flush) begin
         state   <= S_IDLE;
         cdb_req <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (fu_start) begin
               op_a  <= fu_op1;
               op_b  <= fu_op2;
               opc   <= fu_opcode;
               tag_q <= fu_dest_tag;
               rd_q  <= fu_dest_reg;
               if (!is_div_op(fu_opcode)) begin
                  state <= S_MUL;
               end else if (div_zero || div_ovf) begin
                  state        <= S_DONE;
                  cdb_req      <= 1'b1;
                  cdb_value    <= special_val;
                  cdb_tag      <= fu_dest_tag;
                  cdb_dest_reg <= fu_dest_reg;
               end else begin
                  state <= S_DIV;
               end
            end
            S_MUL: begin
               state        <= S_DONE;
               cdb_req      <= 1'b1;
               cdb_value    <= mul_val;
               cdb_tag      <= tag_q;
               cdb_dest_reg <= rd_q;
            end
            S_DIV: if (div_done) begin
               state        <= S_DONE;
               cdb_req      <= 1'b1;
               cdb_value    <= div_val;
               cdb_tag      <= tag_q;
               cdb_dest_reg <= rd_q;
            end
            S_DONE: if (cdb_grant) begin
               state   <= S_IDLE;
               cdb_req <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized operations
// against an arithmetic reference model, grant stall, flush and mid-op reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        fu_start;
   logic [31:0] fu_op1, fu_op2, fu_op3;
   logic [4:0]  fu_opcode;
   logic [2:0]  fu_dest_tag;
   logic [4:0]  fu_dest_reg;
   logic        fu_ready;
   logic        flush;
   logic        cdb_req;
   logic        cdb_grant;
   logic [2:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic [4:0]  cdb_dest_reg;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.DATA_WIDTH(32), .TAG_WIDTH(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .fu_start     (fu_start),
      .fu_op1       (fu_op1),
      .fu_op2       (fu_op2),
      .fu_op3       (fu_op3),
      .fu_opcode    (fu_opcode),
      .fu_dest_tag  (fu_dest_tag),
      .fu_dest_reg  (fu_dest_reg),
      .fu_ready     (fu_ready),
      .flush        (flush),
      .cdb_req      (cdb_req),
      .cdb_grant    (cdb_grant),
      .cdb_tag      (cdb_tag),
      .cdb_value    (cdb_value),
      .cdb_dest_reg (cdb_dest_reg)
   );

   // Reference model: RV32M semantics via 64-bit integer arithmetic.
   function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'b0, a});
      ub = longint'({32'b0, b});
      case (op)
         5'd0: begin p = 64'(sa * sb); return p[31:0]; end
         5'd1: begin p = 64'(sa * sb); return p[63:32]; end
         5'd2: begin p = 64'(sa * ub); return p[63:32]; end
         5'd3: begin p = 64'(ua * ub); return p[63:32]; end
         5'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
         5'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
         5'd6: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
         5'd7: begin if (b == 0) return a; return a % b; end
         default: return 32'h0;
      endcase
   endfunction

   function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < 5'd4 || op > 5'd7) return 2;
      if (b == 0) return 1;
      if ((op == 5'd4 || op == 5'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] tag, input logic [4:0] rd);
      fu_opcode   = op;
      fu_op1      = a;
      fu_op2      = b;
      fu_op3      = $urandom;
      fu_dest_tag = tag;
      fu_dest_reg = rd;
      fu_start    = 1'b1;
   endtask

   // Called at the issue negedge; returns cycles until cdb_req and how many
   // cycles showed fu_ready high while the op was outstanding.
   task automatic wait_req(output int lat, output int ready_bad);
      lat = 0;
      ready_bad = 0;
      #1;
      if (fu_ready) ready_bad++;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) fu_start = 1'b0;
         #1;
         if (fu_ready) ready_bad++;
      end while (!cdb_req && lat < 60);
   endtask

   task automatic grant_now();
      cdb_grant = 1'b1;
      @(negedge clk);
      cdb_grant = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; fu_start = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
      fu_op1 = '0; fu_op2 = '0; fu_op3 = '0; fu_opcode = '0; fu_dest_tag = '0; fu_dest_reg = '0;
      repeat (2) @(negedge clk);
      checks++; if (cdb_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", cdb_req); end
      checks++; if (cdb_value !== 32'h0) begin errors++; $display("FAIL reset_value got=%h exp=0", cdb_value); end
      checks++; if (cdb_tag !== 3'h0) begin errors++; $display("FAIL reset_tag got=%0d exp=0", cdb_tag); end
      checks++; if (cdb_dest_reg !== 5'h0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", cdb_dest_reg); end
      checks++; if (fu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", fu_ready); end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [4:0]  vop [12] = '{5'd0, 5'd3, 5'd1, 5'd2, 5'd4, 5'd6, 5'd7, 5'd5, 5'd6, 5'd4, 5'd6, 5'd9};
      logic [31:0] va  [12] = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 32'hFFFF_FFEC,
                                32'd20, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd123};
      logic [31:0] vb  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd3, 32'd3,
                                32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd456};
      logic [31:0] vexp[12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE,
                                32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd0};
      int          vlat[12] = '{2, 2, 2, 2, 33, 33, 33, 1, 1, 1, 1, 2};
      int lat, rb;
      logic [2:0] tag;
      logic [4:0] rd;
      for (int i = 0; i < 12; i++) begin
         tag = (i == 0) ? 3'd5 : 3'(i);
         rd  = (i == 0) ? 5'd10 : 5'(i + 12);
         @(negedge clk);
         start_op(vop[i], va[i], vb[i], tag, rd);
         wait_req(lat, rb);
         checks++; if (lat != vlat[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, vlat[i]); end
         checks++; if (cdb_value !== vexp[i]) begin errors++; $display("FAIL dir%0d_value got=%h exp=%h", i, cdb_value, vexp[i]); end
         checks++; if (cdb_tag !== tag || cdb_dest_reg !== rd) begin
            errors++; $display("FAIL dir%0d_tag_rd got=%0d/%0d exp=%0d/%0d", i, cdb_tag, cdb_dest_reg, tag, rd); end
         checks++; if (rb != 0) begin errors++; $display("FAIL dir%0d_ready_busy got=%0d exp=0 cycles high", i, rb); end
         grant_now();
         checks++; if (cdb_req !== 1'b0 || fu_ready !== 1'b1) begin
            errors++; $display("FAIL dir%0d_after_grant req=%0b ready=%0b exp 0/1", i, cdb_req, fu_ready); end
      end
   endtask

   task automatic test_random();
      logic [4:0]  op;
      logic [31:0] a, b, exp;
      logic [2:0]  tag;
      logic [4:0]  rd;
      int lat, rb, elat;
      for (int i = 0; i < 30; i++) begin
         op = 5'($urandom_range(0, 12));
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = $urandom_range(0, 100); b = $urandom_range(1, 9); end
            3: b = 32'($urandom_range(1, 300)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
            default: ;
         endcase
         tag = 3'($urandom_range(0, 7));
         rd  = 5'($urandom_range(0, 31));
         exp  = ref_result(op, a, b);
         elat = ref_latency(op, a, b);
         @(negedge clk);
         start_op(op, a, b, tag, rd);
         wait_req(lat, rb);
         checks++; if (lat != elat) begin errors++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, op, lat, elat); end
         checks++; if (cdb_value !== exp || cdb_tag !== tag || cdb_dest_reg !== rd) begin
            errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h/%0d/%0d exp=%h/%0d/%0d",
                               i, op, a, b, cdb_value, cdb_tag, cdb_dest_reg, exp, tag, rd); end
         checks++; if (rb != 0) begin errors++; $display("FAIL rnd%0d_ready_busy got=%0d exp=0", i, rb); end
         grant_now();
      end
   endtask

   task automatic test_grant_withheld();
      int lat, rb, bad;
      @(negedge clk);
      start_op(5'd0, 32'd1234, 32'd5678, 3'd6, 5'd7);
      wait_req(lat, rb);
      checks++; if (lat != 2 || cdb_value !== 32'd7006652) begin
         errors++; $display("FAIL hold_first got lat=%0d val=%h exp lat=2 val=%h", lat, cdb_value, 32'd7006652); end
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (cdb_req !== 1'b1 || cdb_value !== 32'd7006652 || cdb_tag !== 3'd6 || cdb_dest_reg !== 5'd7 || fu_ready !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad); end
      grant_now();
      checks++; if (fu_ready !== 1'b1 || cdb_req !== 1'b0) begin
         errors++; $display("FAIL hold_release ready=%0b req=%0b exp 1/0", fu_ready, cdb_req); end
      start_op(5'd3, 32'hFFFF_FFFF, 32'd2, 3'd1, 5'd2);
      wait_req(lat, rb);
      checks++; if (lat != 2 || cdb_value !== 32'd1 || cdb_tag !== 3'd1) begin
         errors++; $display("FAIL hold_second got lat=%0d val=%h tag=%0d exp lat=2 val=1 tag=1", lat, cdb_value, cdb_tag); end
      grant_now();
   endtask

   task automatic test_flush();
      int lat, rb, seen;
      @(negedge clk);
      start_op(5'd4, 32'd1000, 32'd7, 3'd2, 5'd3);
      seen = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) fu_start = 1'b0;
         if (cdb_req) seen++;
         if (k == 10) flush = 1'b1;
      end
      @(negedge clk);
      flush = 1'b0;
      #1;
      checks++; if (seen != 0 || cdb_req !== 1'b0 || fu_ready !== 1'b1) begin
         errors++; $display("FAIL flush_idle seen=%0d req=%0b ready=%0b exp 0/0/1", seen, cdb_req, fu_ready); end
      start_op(5'd0, 32'd6, 32'd7, 3'd4, 5'd9);
      wait_req(lat, rb);
      checks++; if (lat != 2 || cdb_value !== 32'd42 || cdb_tag !== 3'd4 || cdb_dest_reg !== 5'd9) begin
         errors++; $display("FAIL flush_next got lat=%0d val=%h exp lat=2 val=2a", lat, cdb_value); end
      grant_now();
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (cdb_req) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL flush_no_late_req got=%0d exp=0", seen); end
      // A start coinciding with flush must be dropped.
      start_op(5'd5, 32'd9, 32'd0, 3'd7, 5'd1);
      flush = 1'b1;
      @(negedge clk);
      fu_start = 1'b0;
      flush = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (cdb_req || !fu_ready) seen++;
         @(negedge clk);
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL flush_drop_start got=%0d busy cycles exp=0", seen); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start_op(5'd7, 32'd99999, 32'd13, 3'd3, 5'd30);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) fu_start = 1'b0;
      end
      rst = 1'b1;
      #1;
      checks++; if (cdb_req !== 1'b0 || cdb_value !== 32'h0 || cdb_tag !== 3'h0 || cdb_dest_reg !== 5'h0) begin
         errors++; $display("FAIL midreset_outputs req=%0b val=%h tag=%0d rd=%0d exp all 0", cdb_req, cdb_value, cdb_tag, cdb_dest_reg); end
      checks++; if (fu_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%0b exp=1", fu_ready); end
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (cdb_req !== 1'b0 || fu_ready !== 1'b1) begin
         errors++; $display("FAIL midreset_after req=%0b ready=%0b exp 0/1", cdb_req, fu_ready); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_grant_withheld();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
